// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS main control FSM and its datapath.
// master = control unit (drives enables/selects), slave = datapath side.
interface multicycle_control_if #(
    parameter int unsigned STATE_W = 4
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_source;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore main control FSM for the multicycle MIPS datapath.
// Define MC_ADDI_EN to add the addi path (ADDI_EXEC/ADDI_WB states).
module multicycle_control #(
    parameter int unsigned STATE_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    localparam int unsigned OPC_W = 6;
    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
`ifdef MC_ADDI_EN
        ,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
`endif
    } state_e;

    state_e state_q, state_d;

    logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
    logic       ir_write_c, mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
    logic       illegal_op_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next state and Moore outputs; reset masks writes and shows FETCH selects.
    always_comb begin
        state_d         = S_FETCH;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        mem_to_reg_c    = 1'b0;
        reg_dst_c       = 1'b0;
        reg_write_c     = 1'b0;
        alu_src_a_c     = 1'b0;
        illegal_op_c    = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;
        pc_source_c     = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
                state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
                    default:      illegal_op_c = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                if (bus.opcode == OP_LW)      state_d = S_MEM_READ;
                else if (bus.opcode == OP_SW) state_d = S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                state_d    = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                state_d     = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 2'b01;
            end
            S_JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_c = 1'b1;
            end
`endif
            default: ;
        endcase

        if (rst) begin
            pc_write_c      = 1'b0;
            pc_write_cond_c = 1'b0;
            i_or_d_c        = 1'b0;
            mem_read_c      = 1'b1;
            mem_write_c     = 1'b0;
            ir_write_c      = 1'b0;
            mem_to_reg_c    = 1'b0;
            reg_dst_c       = 1'b0;
            reg_write_c     = 1'b0;
            alu_src_a_c     = 1'b0;
            illegal_op_c    = 1'b0;
            alu_src_b_c     = 2'b01;
            alu_op_c        = 2'b00;
            pc_source_c     = 2'b00;
        end
    end

    assign bus.pc_write      = pc_write_c;
    assign bus.pc_write_cond = pc_write_cond_c;
    assign bus.i_or_d        = i_or_d_c;
    assign bus.mem_read      = mem_read_c;
    assign bus.mem_write     = mem_write_c;
    assign bus.ir_write      = ir_write_c;
    assign bus.mem_to_reg    = mem_to_reg_c;
    assign bus.reg_dst       = reg_dst_c;
    assign bus.reg_write     = reg_write_c;
    assign bus.alu_src_a     = alu_src_a_c;
    assign bus.alu_src_b     = alu_src_b_c;
    assign bus.alu_op        = alu_op_c;
    assign bus.pc_source     = pc_source_c;
    assign bus.illegal_op    = illegal_op_c;
    assign bus.state         = STATE_W'(state_q);
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle MIPS datapath, sitting directly upstream of the ALU control decoder. It is a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back steps. Every cycle it drives the datapath enables and multiplexer selects, and it supplies the 2-bit ALU operation class (`alu_op`) that the ALU control decoder combines with the function field. A `mem_ready` handshake stretches memory states for slow memory.

## Interface
- `STATE_W`, default 4: width of the state register; must be ≥ 4.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  `IR[31:26]`; stable from the cycle after FETCH completes.
- `mem_ready`  in  1  memory completed the current access this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load qualified by ALU zero (branch).
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  instruction register load.
- `mem_to_reg`  out  1  write-back data select: 1 = MDR, 0 = ALUOut.
- `reg_dst`  out  1  destination register select: 1 = rd, 0 = rt.
- `reg_write`  out  1  register file write.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = use function field.
- `pc_source`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op`  out  1  unrecognised opcode detected in DECODE.
- `state`  out  `STATE_W`  current state, for debug.

## Operation
- Outputs are decoded combinationally from the state only. Exceptions: `ir_write` and `pc_write` in FETCH equal `mem_ready`, and `illegal_op` is decoded in DECODE from `opcode`.
- Any output not listed for a state below is 0.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000 (addi only with the configuration macro).

State behaviour and transitions:
- **FETCH (0)**
  - Outputs: `mem_read`=1, `alu_src_b`=01, `alu_op`=00, `pc_source`=00, `ir_write`=`pc_write`=`mem_ready`.
  - Next state: DECODE if `mem_ready`, else stay in FETCH.
- **DECODE (1)**
  - Outputs: `alu_src_b`=11, `alu_op`=00.
  - Next state: lw/sw→MEM_ADDR, R-type→EXECUTE, beq→BRANCH, j→JUMP, addi→ADDI_EXEC.
  - Any other opcode: `illegal_op`=1 for this cycle only, next state FETCH.
- **MEM_ADDR (2)**
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Next state: lw→MEM_READ, sw→MEM_WRITE.
- **MEM_READ (3)**
  - Outputs: `mem_read`=1, `i_or_d`=1.
  - Next state: MEM_WB if `mem_ready`, else stay.
- **MEM_WB (4)**
  - Outputs: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - Next state: FETCH.
- **MEM_WRITE (5)**
  - Outputs: `mem_write`=1, `i_or_d`=1.
  - Next state: FETCH if `mem_ready`, else stay.
- **EXECUTE (6)**
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - Next state: R_WB.
- **R_WB (7)**
  - Outputs: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0.
  - Next state: FETCH.
- **BRANCH (8)**
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - Next state: FETCH.
- **JUMP (9)**
  - Outputs: `pc_write`=1, `pc_source`=10.
  - Next state: FETCH.
- **ADDI_EXEC (10)**
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Next state: ADDI_WB.
- **ADDI_WB (11)**
  - Outputs: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
  - Next state: FETCH.
- **Unused encodings**: all outputs 0, next state FETCH.

## Timing
- **Reset**
  - `rst` high at a clock edge loads `state`=0 (FETCH).
  - While `rst` is high, `pc_write`, `pc_write_cond`, `ir_write`, `mem_write`, `reg_write` and `illegal_op` are forced to 0.
  - All other outputs show their FETCH values.
  - Reset mid-instruction abandons the instruction; no partial write-back occurs after the reset edge.
- **Cycles per instruction with `mem_ready` held at 1**: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- **Memory wait states**: each cycle `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
  - While waiting, `mem_read`/`mem_write` and `i_or_d` stay stable.
  - `pc_write` and `ir_write` do not fire during the wait.
- **Stray `mem_ready`**: `mem_ready` in any non-memory state is ignored.
- **Opcode sampling**: `opcode` is sampled only in DECODE and MEM_ADDR.

## Configuration
- **`MC_ADDI_EN` defined**: the addi opcode (001000) takes DECODE→ADDI_EXEC→ADDI_WB→FETCH.
- **`MC_ADDI_EN` undefined**:
  - States 10 and 11 are not generated.
  - Opcode 001000 is illegal: `illegal_op` pulses in DECODE and the next state is FETCH.

## Test plan
- **Reset**: assert `rst` for 2 cycles from arbitrary state 7 → `state`=0, all write enables 0, `mem_read`=1, `alu_src_b`=01.
- **lw, no wait**: `mem_ready`=1, `opcode`=100011 → states 0,1,2,3,4,0; `reg_write`=1 and `mem_to_reg`=1 only in state 4; `ir_write` only in state 0.
- **sw with memory wait**: `opcode`=101011, `mem_ready` low for 2 cycles in MEM_WRITE → `mem_write` held for 3 cycles, then FETCH; `reg_write` never asserted.
- **R-type then beq**: R-type gives `alu_op`=10 in state 6 and `reg_dst`=1 in state 7; beq gives `alu_op`=01, `pc_write_cond`=1, `pc_source`=01 in state 8.
- **Jump and illegal opcode**: j gives `pc_write`=1, `pc_source`=10 in state 9; opcode 111111 gives `illegal_op`=1 for exactly one cycle in DECODE, then FETCH.
- **addi both builds**: opcode 001000 follows 0,1,10,11,0 with `MC_ADDI_EN` defined; without it, `illegal_op` pulses and the FSM returns to FETCH.
